// File: rtl/irq_prio_pkg.sv
// rtl/irq_prio_pkg.sv - shared types and width helpers for the interrupt priority arbiter
package irq_prio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Index width that stays at least one bit wide for single-entry sets.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_arbiter_prio_enc.sv
// rtl/irq_prio_arbiter_prio_enc.sv - lowest-index-first priority encoder (module prio_enc)
module prio_enc #(
  parameter int N = 9,
  parameter int W = 4
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         hit
);

  // Scan from the top down so the lowest set index is the last write.
  always_comb begin
    idx = '0;
    hit = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/irq_prio_arbiter.sv
// rtl/irq_prio_arbiter.sv - multi-bus latched interrupt arbiter with grant/ack handshake
module irq_prio_arbiter
  import irq_prio_pkg::*;
#(
  parameter int N_CH  = 9,
  parameter int N_BUS = 3,
  parameter int EDGE  = 1,
  localparam int CH_W  = idx_width(N_CH),
  localparam int BUS_W = idx_width(N_BUS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_BUS*N_CH-1:0]   req_i,
  input  logic [N_CH-1:0]         en_i,
  input  logic                    ack_i,
  output logic                    irq_o,
  output logic [BUS_W-1:0]        bus_o,
  output logic [CH_W-1:0]         chan_o,
  output logic [N_BUS-1:0]        bus_hit_o,
  output logic [N_BUS*N_CH-1:0]   pend_o
);

  state_t                      state;
  logic [N_BUS*N_CH-1:0]       req_q;
  logic [N_BUS*N_CH-1:0]       pend;
  logic [N_BUS*N_CH-1:0]       set_vec;
  logic [N_BUS*N_CH-1:0]       clr_vec;
  logic [N_BUS-1:0][N_CH-1:0]  elig;
  logic [CH_W-1:0]             ch_idx [N_BUS];
  logic [N_BUS-1:0]            bus_hit_c;
  logic [BUS_W-1:0]            win_bus;
  logic [CH_W-1:0]             win_chan;
  logic                        any_hit;
  logic                        win_en;
  logic                        ack_grant;

  assign pend_o    = pend;
  assign elig      = pend & {N_BUS{en_i}};
  assign ack_grant = (state == ST_GRANT) && ack_i;

  generate
    if (EDGE != 0) begin : g_edge
      assign set_vec = req_i & ~req_q;
    end else begin : g_level
      assign set_vec = req_i;
    end
  endgenerate

  for (genvar b = 0; b < N_BUS; b++) begin : g_ch_enc
    prio_enc #(.N(N_CH), .W(CH_W)) u_ch_enc (
      .vec (elig[b]),
      .idx (ch_idx[b]),
      .hit (bus_hit_c[b])
    );
  end

  prio_enc #(.N(N_BUS), .W(BUS_W)) u_bus_enc (
    .vec (bus_hit_c),
    .idx (win_bus),
    .hit (any_hit)
  );

  assign win_chan = ch_idx[win_bus];

  // Decode the frozen vector back to a flat one-hot clear and its enable bit.
  always_comb begin
    clr_vec = '0;
    win_en  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (chan_o == CH_W'(c)) win_en = en_i[c];
    end
    for (int b = 0; b < N_BUS; b++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (ack_grant && bus_o == BUS_W'(b) && chan_o == CH_W'(c))
          clr_vec[b*N_CH + c] = 1'b1;
      end
    end
  end

  // Set is OR-ed after the clear so a re-asserting request wins the race.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
      pend  <= '0;
    end else begin
      req_q <= req_i;
      pend  <= (pend & ~clr_vec) | set_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      irq_o     <= 1'b0;
      bus_o     <= '0;
      chan_o    <= '0;
      bus_hit_o <= '0;
    end else begin
      bus_hit_o <= bus_hit_c;
      case (state)
        ST_IDLE: begin
          if (any_hit) begin
            state  <= ST_GRANT;
            irq_o  <= 1'b1;
            bus_o  <= win_bus;
            chan_o <= win_chan;
          end
        end
        ST_GRANT: begin
          // Ack takes precedence; a masked winner is withdrawn but stays pending.
          if (ack_i || !win_en) begin
            state <= ST_GAP;
            irq_o <= 1'b0;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
          irq_o <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          irq_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_prio_arbiter.sv
// tb/tb_irq_prio_arbiter.sv - directed self-checking bench for irq_prio_arbiter
module tb_irq_prio_arbiter;

  localparam int N_CH  = 9;
  localparam int N_BUS = 3;
  localparam int NB    = N_BUS * N_CH;

  logic            clk = 1'b0;
  logic            rst = 1'b1;

  logic [NB-1:0]   req   = '0;
  logic [N_CH-1:0] en    = '1;
  logic            ack   = 1'b0;
  logic            irq;
  logic [1:0]      bus;
  logic [3:0]      chan;
  logic [2:0]      bus_hit;
  logic [NB-1:0]   pend;

  logic [NB-1:0]   req_l = '0;
  logic [N_CH-1:0] en_l  = '1;
  logic            ack_l = 1'b0;
  logic            irq_l;
  logic [1:0]      bus_l;
  logic [3:0]      chan_l;
  logic [2:0]      bus_hit_l;
  logic [NB-1:0]   pend_l;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  irq_prio_arbiter #(.N_CH(N_CH), .N_BUS(N_BUS), .EDGE(1)) dut (
    .clk(clk), .rst(rst), .req_i(req), .en_i(en), .ack_i(ack),
    .irq_o(irq), .bus_o(bus), .chan_o(chan), .bus_hit_o(bus_hit), .pend_o(pend)
  );

  irq_prio_arbiter #(.N_CH(N_CH), .N_BUS(N_BUS), .EDGE(0)) dut_lvl (
    .clk(clk), .rst(rst), .req_i(req_l), .en_i(en_l), .ack_i(ack_l),
    .irq_o(irq_l), .bus_o(bus_l), .chan_o(chan_l), .bus_hit_o(bus_hit_l), .pend_o(pend_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB-1:0] bit_of(input int b, input int c);
    logic [NB-1:0] v;
    v = '0;
    v[b*N_CH + c] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({irq, bus, chan, bus_hit, pend} !== '0) begin
      $display("FAIL reset_outputs irq=%0b bus=%0d chan=%0d hit=%b pend=%h expected all zero",
               irq, bus, chan, bus_hit, pend);
    end else pass_cnt++;
    total++;
    if ({irq_l, pend_l} !== '0) $display("FAIL reset_lvl irq=%0b pend=%h expected 0", irq_l, pend_l);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    en  = '1;
    req = bit_of(1, 4);
    tick();
    total++;
    if (pend !== bit_of(1, 4) || irq !== 1'b0)
      $display("FAIL single_pend pend=%h irq=%0b expected pend=%h irq=0", pend, irq, bit_of(1, 4));
    else pass_cnt++;
    req = '0;
    tick();
    total++;
    if (irq !== 1'b1 || bus !== 2'd1 || chan !== 4'd4 || bus_hit !== 3'b010)
      $display("FAIL single_grant irq=%0b bus=%0d chan=%0d hit=%b expected 1,1,4,010",
               irq, bus, chan, bus_hit);
    else pass_cnt++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++;
    if (irq !== 1'b0 || pend !== '0)
      $display("FAIL single_ack irq=%0b pend=%h expected irq=0 pend=0", irq, pend);
    else pass_cnt++;
    tick();
    tick();
    total++;
    if (irq !== 1'b0 || bus_hit !== 3'b000)
      $display("FAIL single_quiet irq=%0b hit=%b expected 0,000", irq, bus_hit);
    else pass_cnt++;
  endtask

  task automatic test_order();
    logic [1:0] exp_b [3] = '{2'd0, 2'd0, 2'd2};
    logic [3:0] exp_c [3] = '{4'd3, 4'd8, 4'd0};
    req = bit_of(2, 0) | bit_of(0, 8) | bit_of(0, 3);
    tick();
    req = '0;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (irq !== 1'b1 || bus !== exp_b[k] || chan !== exp_c[k])
        $display("FAIL order_%0d irq=%0b bus=%0d chan=%0d expected 1,%0d,%0d",
                 k, irq, bus, chan, exp_b[k], exp_c[k]);
      else pass_cnt++;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      total++;
      if (irq !== 1'b0) $display("FAIL order_gap_%0d irq=%0b expected 0", k, irq);
      else pass_cnt++;
      tick();
      if (k < 2) tick();
    end
    tick();
    total++;
    if (irq !== 1'b0 || pend !== '0)
      $display("FAIL order_drain irq=%0b pend=%h expected 0,0", irq, pend);
    else pass_cnt++;
  endtask

  task automatic test_mask();
    en  = 9'h1DF;
    req = bit_of(0, 5);
    tick();
    req = '0;
    tick();
    tick();
    total++;
    if (irq !== 1'b0 || pend !== bit_of(0, 5) || bus_hit !== 3'b000)
      $display("FAIL mask_hold irq=%0b pend=%h hit=%b expected 0,%h,000",
               irq, pend, bus_hit, bit_of(0, 5));
    else pass_cnt++;
    en = '1;
    tick();
    total++;
    if (irq !== 1'b1 || bus !== 2'd0 || chan !== 4'd5)
      $display("FAIL mask_release irq=%0b bus=%0d chan=%0d expected 1,0,5", irq, bus, chan);
    else pass_cnt++;
    en = 9'h1DF;
    tick();
    total++;
    if (irq !== 1'b0 || pend !== bit_of(0, 5))
      $display("FAIL mask_withdraw irq=%0b pend=%h expected 0,%h", irq, pend, bit_of(0, 5));
    else pass_cnt++;
    en = '1;
    tick();
    tick();
    total++;
    if (irq !== 1'b1 || chan !== 4'd5)
      $display("FAIL mask_regrant irq=%0b chan=%0d expected 1,5", irq, chan);
    else pass_cnt++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_no_preempt();
    req = bit_of(2, 1);
    tick();
    req = '0;
    tick();
    req = bit_of(0, 0);
    tick();
    req = '0;
    tick();
    total++;
    if (irq !== 1'b1 || bus !== 2'd2 || chan !== 4'd1 || bus_hit !== 3'b101)
      $display("FAIL preempt_hold irq=%0b bus=%0d chan=%0d hit=%b expected 1,2,1,101",
               irq, bus, chan, bus_hit);
    else pass_cnt++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++;
    if (irq !== 1'b0 || pend !== bit_of(0, 0))
      $display("FAIL preempt_ack irq=%0b pend=%h expected 0,%h", irq, pend, bit_of(0, 0));
    else pass_cnt++;
    tick();
    tick();
    total++;
    if (irq !== 1'b1 || bus !== 2'd0 || chan !== 4'd0)
      $display("FAIL preempt_next irq=%0b bus=%0d chan=%0d expected 1,0,0", irq, bus, chan);
    else pass_cnt++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_level();
    req_l = bit_of(1, 2);
    tick();
    tick();
    total++;
    if (irq_l !== 1'b1 || bus_l !== 2'd1 || chan_l !== 4'd2)
      $display("FAIL level_grant irq=%0b bus=%0d chan=%0d expected 1,1,2", irq_l, bus_l, chan_l);
    else pass_cnt++;
    ack_l = 1'b1;
    tick();
    ack_l = 1'b0;
    total++;
    if (irq_l !== 1'b0 || pend_l !== bit_of(1, 2))
      $display("FAIL level_repend irq=%0b pend=%h expected 0,%h", irq_l, pend_l, bit_of(1, 2));
    else pass_cnt++;
    tick();
    tick();
    total++;
    if (irq_l !== 1'b1 || bus_l !== 2'd1 || chan_l !== 4'd2)
      $display("FAIL level_regrant irq=%0b bus=%0d chan=%0d expected 1,1,2", irq_l, bus_l, chan_l);
    else pass_cnt++;
    req_l = '0;
    ack_l = 1'b1;
    tick();
    ack_l = 1'b0;
    tick();
    tick();
    total++;
    if (irq_l !== 1'b0 || pend_l !== '0)
      $display("FAIL level_idle irq=%0b pend=%h expected 0,0", irq_l, pend_l);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_grant();
    req = bit_of(1, 1) | bit_of(2, 2);
    tick();
    req = '0;
    tick();
    total++;
    if (irq !== 1'b1 || bus !== 2'd1 || chan !== 4'd1)
      $display("FAIL rst_pre irq=%0b bus=%0d chan=%0d expected 1,1,1", irq, bus, chan);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (irq !== 1'b0 || pend !== '0 || bus !== 2'd0 || chan !== 4'd0)
      $display("FAIL rst_mid irq=%0b pend=%h bus=%0d chan=%0d expected all zero", irq, pend, bus, chan);
    else pass_cnt++;
    req = bit_of(0, 3) | bit_of(0, 4);
    tick();
    req = '0;
    tick();
    ack = 1'b1;
    tick();
    tick();
    total++;
    if (irq !== 1'b0 || pend !== bit_of(0, 4))
      $display("FAIL gap_ack irq=%0b pend=%h expected 0,%h", irq, pend, bit_of(0, 4));
    else pass_cnt++;
    ack = 1'b0;
    tick();
    total++;
    if (irq !== 1'b1 || bus !== 2'd0 || chan !== 4'd4)
      $display("FAIL gap_next irq=%0b bus=%0d chan=%0d expected 1,0,4", irq, bus, chan);
    else pass_cnt++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_mask();
    test_no_preempt();
    test_level();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
